// File: rtl/otter_hazard_ctrl.sv
// Scoreboard-based hazard/forwarding controller for the pipelined OTTER core.
// Optional build macro HAZ_PERF_CNT_EN adds stall_cnt/flush_cnt event counters.
module otter_hazard_ctrl #(
  parameter int DEPTH        = 2,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int RA_W         = 5,
  localparam int SEL_W       = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_rf_we,
  input  logic             id_is_load,
  input  logic             br_taken,
  output logic             stall,
  output logic             flush,
  output logic [SEL_W-1:0] fwd_sel_rs1,
  output logic [SEL_W-1:0] fwd_sel_rs2
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  typedef struct packed {
    logic            vld;
    logic [RA_W-1:0] rd;
    logic            is_load;
  } sb_entry_t;

  // FLUSH_CYCLES tops out at 7, so a fixed 3-bit countdown always suffices.
  localparam logic [2:0] FCNT_RELOAD = 3'(FLUSH_CYCLES - 1);

  sb_entry_t  sb_q [1:DEPTH];
  sb_entry_t  sb_in;
  logic [2:0] fcnt_q;
  logic       rs1_wait;
  logic       rs2_wait;

  assign flush = br_taken || (fcnt_q != 3'd0);

  // Scan oldest to youngest so the youngest matching writer overwrites older ones.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves a latch.
    fwd_sel_rs1 = '0;
    fwd_sel_rs2 = '0;
    rs1_wait    = 1'b0;
    rs2_wait    = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_rs1_used && (id_rs1 != '0) && sb_q[k].vld && (sb_q[k].rd == id_rs1)) begin
        fwd_sel_rs1 = SEL_W'(k);
        rs1_wait    = sb_q[k].is_load && (k <= LOAD_LAT);
      end
      if (id_rs2_used && (id_rs2 != '0) && sb_q[k].vld && (sb_q[k].rd == id_rs2)) begin
        fwd_sel_rs2 = SEL_W'(k);
        rs2_wait    = sb_q[k].is_load && (k <= LOAD_LAT);
      end
    end
    stall = !flush && id_valid && (rs1_wait || rs2_wait);
  end

  // A stalled or squashed decode slot enters EX as a bubble.
  always_comb begin
    sb_in = '0;
    if (!stall && !flush && id_valid && id_rf_we && (id_rd != '0)) begin
      sb_in.vld     = 1'b1;
      sb_in.rd      = id_rd;
      sb_in.is_load = id_is_load;
    end
  end

  // Stages after ID are never held: the scoreboard shifts every clock.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: only vld needs a reset value; clearing whole entries keeps X out of the compares.
      for (int k = 1; k <= DEPTH; k++) sb_q[k] <= '0;
      fcnt_q <= 3'd0;
    end else begin
      // NOTE: non-blocking assignments let every stage read its predecessor's old value.
      sb_q[1] <= sb_in;
      for (int k = 2; k <= DEPTH; k++) sb_q[k] <= sb_q[k-1];
      if (br_taken)              fcnt_q <= FCNT_RELOAD;
      else if (fcnt_q != 3'd0)   fcnt_q <= fcnt_q - 3'd1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (stall) stall_cnt <= stall_cnt + 32'd1;
      if (flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule
